qa_driver_mem_responder: RTL
============================

Name: qa_driver_mem_responder

Overview:
- Memory-side responder for the QA driver's CCI request stream: the far end of the client read/write request interface.
- Accepts cache-line read and write requests, stores lines in a local RAM, and returns read data and write acks carrying the request mdata.
- Used as an FIU-side host-memory stand-in for standalone AFU/driver simulation and loopback bring-up on FPGA.

Parameters:
- MEM_ADDR_BITS, 10, log2 of RAM depth in cache lines (1024 lines by default).
- REQ_FIFO_DEPTH, 16, entries per request FIFO (read and write); power of 2, minimum 8.
- ALMFULL_SLACK, 8, free entries reserved after almFull asserts; must be less than REQ_FIFO_DEPTH.
- RD_LATENCY, 4, cycles from RAM issue to rd_rsp_valid; minimum 1.

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  read request strobe
- rd_req_addr  in  42  cache-line address (t_cci_clAddr)
- rd_req_mdata  in  16  request tag (t_cci_mdata)
- rd_req_almfull  out  1  read FIFO almost full
- wr_req_valid  in  1  write request strobe
- wr_req_addr  in  42  cache-line address
- wr_req_data  in  512  line data (t_cci_cldata)
- wr_req_mdata  in  16  request tag
- wr_req_almfull  out  1  write FIFO almost full
- rd_rsp_valid  out  1  read response strobe
- rd_rsp_data  out  512  read line data
- rd_rsp_mdata  out  16  echoed tag
- wr_rsp_valid  out  1  write ack strobe
- wr_rsp_mdata  out  16  echoed tag
- err_overflow  out  1  sticky: request arrived while its FIFO was full

Behaviour:
- Reset (asynchronous assert, synchronous-release use):
  - All valid outputs, almfull outputs and err_overflow drive 0.
  - FIFOs empty; read pipeline flushed; arbiter pointer set to write.
  - RAM contents are not cleared and are undefined after power-up.
  - Reset asserted mid-operation discards every queued and in-flight request; no responses are emitted for them.
- Enqueue:
  - A valid request is written to its FIFO in the same cycle.
  - almfull is registered and asserts when occupancy >= REQ_FIFO_DEPTH - ALMFULL_SLACK.
  - almfull deasserts in the cycle after occupancy drops below the threshold.
  - Valid on a full FIFO: the request is dropped, err_overflow is set and stays set until reset.
- Arbitration:
  - One RAM access per cycle.
  - Only one FIFO head valid: that head is served.
  - Both heads valid: round-robin, and the pointer flips after each contended grant.
  - The first contended grant after reset goes to write.
  - No address-hazard checking between the read and write queues; ordering across queues follows the grant order only.
- Address: RAM index is addr[MEM_ADDR_BITS-1:0]; upper bits are ignored, so addresses alias modulo 2^MEM_ADDR_BITS.
- Write grant at cycle N:
  - RAM is written at the N clock edge.
  - wr_rsp_valid=1 with the echoed mdata in cycle N+1.
- Read grant at cycle N:
  - rd_rsp_valid=1 with data and mdata in cycle N+RD_LATENCY.
  - Data reflects all writes granted before cycle N.
  - A write granted in the same cycle is impossible, because there is one grant per cycle.
- Throughput and ordering:
  - One read response and one write ack may occur in the same cycle.
  - Responses within each channel are in request order.
  - Sustained throughput is one request per cycle in total.
- No backpressure on responses; the consumer must always accept them.
- Pop and push on the same cycle on a full FIFO is legal: the push is accepted and no overflow is flagged.

Decomposition:
- Shared package (qa_driver_mem_responder_pkg):
  - t_mem_idx (MEM_ADDR_BITS-wide index).
  - t_rd_req {addr, mdata} and t_wr_req {addr, data, mdata} structs.
  - Default parameter constants.
- One sub-module: qa_driver_mem_responder_fifo, a parameterized-type FIFO with occupancy, almfull and overflow outputs, instantiated twice.
- RAM and latency pipeline are inferred in the top module.

Test Plan:
- Write line 0x5 = {16{32'hDEADBEEF}}, mdata 0x11 -> wr_rsp_valid one cycle after grant with mdata 0x11. Then read 0x5, mdata 0x22 -> rd_rsp_valid exactly 4 cycles after grant with matching data and mdata 0x22.
- Alias check: write addr 0x405 (with MEM_ADDR_BITS=10), then read 0x5 -> returns the line written to 0x405.
- Both FIFOs loaded with 3 requests each, then released together:
  - Grant order is W,R,W,R,W,R.
  - Acks and read responses are interleaved accordingly, each in-order by mdata.
- Ten reads pushed with arbitration stalled by a continuous write stream:
  - rd_req_almfull rises on the cycle after the 8th enqueue (occupancy 8).
  - Falls after occupancy returns to 7.
- Push 17 reads into the depth-16 FIFO with no pops -> err_overflow=1 sticky, and only 16 responses are eventually returned.
- Assert reset_n low with 4 reads in flight:
  - Outputs drop to 0 immediately.
  - No stale rd_rsp_valid appears after release.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/qa_driver_mem_responder_pkg.sv
// rtl/qa_driver_mem_responder_pkg.sv - shared types and defaults for the CCI memory responder
package qa_driver_mem_responder_pkg;

  localparam int MEM_ADDR_BITS_DEF  = 10;
  localparam int REQ_FIFO_DEPTH_DEF = 16;
  localparam int ALMFULL_SLACK_DEF  = 8;
  localparam int RD_LATENCY_DEF     = 4;

  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;
  localparam int MDATA_W   = 16;

  typedef logic [CL_ADDR_W-1:0]         t_cl_addr;
  typedef logic [CL_DATA_W-1:0]         t_cl_data;
  typedef logic [MDATA_W-1:0]           t_mdata;
  typedef logic [MEM_ADDR_BITS_DEF-1:0] t_mem_idx;

  typedef struct packed {
    t_cl_addr addr;
    t_mdata   mdata;
  } t_rd_req;

  typedef struct packed {
    t_cl_addr addr;
    t_cl_data data;
    t_mdata   mdata;
  } t_wr_req;

endpackage

// File: rtl/qa_driver_mem_responder_fifo.sv
// rtl/qa_driver_mem_responder_fifo.sv - request FIFO with occupancy, registered almfull and overflow pulse
module qa_driver_mem_responder_fifo #(
  parameter type T             = logic,
  parameter int  DEPTH         = 16,
  parameter int  ALMFULL_SLACK = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     not_empty,
  output logic                     almfull,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   occupancy
);
  import qa_driver_mem_responder_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] THR_CNT  = (PW+1)'(DEPTH - ALMFULL_SLACK);

  T             mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && full && !do_pop;
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      almfull <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      almfull <= (count >= THR_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qa_driver_mem_responder.sv
// rtl/qa_driver_mem_responder.sv - host-memory stand-in answering CCI read/write requests from a local RAM
module qa_driver_mem_responder
  import qa_driver_mem_responder_pkg::*;
#(
  parameter int MEM_ADDR_BITS  = MEM_ADDR_BITS_DEF,
  parameter int REQ_FIFO_DEPTH = REQ_FIFO_DEPTH_DEF,
  parameter int ALMFULL_SLACK  = ALMFULL_SLACK_DEF,
  parameter int RD_LATENCY     = RD_LATENCY_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           rd_req_valid,
  input  logic [41:0]    rd_req_addr,
  input  logic [15:0]    rd_req_mdata,
  output logic           rd_req_almfull,
  input  logic           wr_req_valid,
  input  logic [41:0]    wr_req_addr,
  input  logic [511:0]   wr_req_data,
  input  logic [15:0]    wr_req_mdata,
  output logic           wr_req_almfull,
  output logic           rd_rsp_valid,
  output logic [511:0]   rd_rsp_data,
  output logic [15:0]    rd_rsp_mdata,
  output logic           wr_rsp_valid,
  output logic [15:0]    wr_rsp_mdata,
  output logic           err_overflow
);

  localparam int OW = $clog2(REQ_FIFO_DEPTH) + 1;

  t_rd_req rd_head;
  t_wr_req wr_head;
  logic    rd_head_v, wr_head_v;
  logic    rd_ovf, wr_ovf;
  logic    grant_rd, grant_wr;
  logic    ptr_wr;
  logic [OW-1:0] rd_occ, wr_occ;

  qa_driver_mem_responder_fifo #(
    .T(t_rd_req), .DEPTH(REQ_FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_rd_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(rd_req_valid), .push_data('{addr: rd_req_addr, mdata: rd_req_mdata}),
    .pop(grant_rd), .head(rd_head), .not_empty(rd_head_v),
    .almfull(rd_req_almfull), .overflow(rd_ovf), .occupancy(rd_occ)
  );

  qa_driver_mem_responder_fifo #(
    .T(t_wr_req), .DEPTH(REQ_FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_wr_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(wr_req_valid),
    .push_data('{addr: wr_req_addr, data: wr_req_data, mdata: wr_req_mdata}),
    .pop(grant_wr), .head(wr_head), .not_empty(wr_head_v),
    .almfull(wr_req_almfull), .overflow(wr_ovf), .occupancy(wr_occ)
  );

  // ptr_wr names the side that wins the next contended cycle.
  assign grant_wr = wr_head_v && (!rd_head_v || ptr_wr);
  assign grant_rd = rd_head_v && (!wr_head_v || !ptr_wr);

  logic [511:0]         ram [2**MEM_ADDR_BITS];
  logic [RD_LATENCY-1:0] rd_pipe_v;
  logic [511:0]         rd_pipe_data  [RD_LATENCY];
  logic [15:0]          rd_pipe_mdata [RD_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_wr       <= 1'b1;
      rd_pipe_v    <= '0;
      wr_rsp_valid <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (rd_head_v && wr_head_v) ptr_wr <= !ptr_wr;
      rd_pipe_v    <= {rd_pipe_v[RD_LATENCY-1:0] << 1} | {{(RD_LATENCY-1){1'b0}}, grant_rd};
      wr_rsp_valid <= grant_wr;
      err_overflow <= err_overflow | rd_ovf | wr_ovf;
    end
  end

  // Data path carries no reset; the valid pipeline alone decides what is emitted.
  always_ff @(posedge clk) begin
    if (grant_wr) ram[wr_head.addr[MEM_ADDR_BITS-1:0]] <= wr_head.data;
    rd_pipe_data[0]  <= ram[rd_head.addr[MEM_ADDR_BITS-1:0]];
    rd_pipe_mdata[0] <= rd_head.mdata;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_pipe_data[i]  <= rd_pipe_data[i-1];
      rd_pipe_mdata[i] <= rd_pipe_mdata[i-1];
    end
    wr_rsp_mdata <= wr_head.mdata;
  end

  assign rd_rsp_valid = rd_pipe_v[RD_LATENCY-1];
  assign rd_rsp_data  = rd_pipe_data[RD_LATENCY-1];
  assign rd_rsp_mdata = rd_pipe_mdata[RD_LATENCY-1];

endmodule
